// File: rtl/chunked_add_sub_if.sv
// Operand/result bundle for chunked_add_sub: start/busy/done handshake, operands and flags.
// The requester uses the master modport and the adder uses the slave modport.
interface chunked_add_sub_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic [N-1:0] num1;
  logic [N-1:0] num2;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic         zero;
  logic         neg;
  logic         ovf;

  modport master (
    output start, num1, num2, cin, sub,
    input  busy, done, sum, cout, zero, neg, ovf
  );

  modport slave (
    input  start, num1, num2, cin, sub,
    output busy, done, sum, cout, zero, neg, ovf
  );
endinterface

// File: rtl/chunked_add_sub.sv
// Multi-cycle adder/subtractor, CHUNK bits per clock, LSB chunk first, registered result + flags.
// Define ADDER_SIGNED_FLAGS_EN to build the neg/ovf flag registers; otherwise both read 0.
module chunked_add_sub #(
  parameter int unsigned N     = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  chunked_add_sub_if.slave  bus
);

  localparam int unsigned C    = N / CHUNK;
  localparam int unsigned IdxW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    part_q, part_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            zero_q, zero_d;
  logic            done_q, done_d;

  logic [CHUNK:0]  chunk_res;
  logic [N-1:0]    res_full;
  logic            last;

  assign last = (state_q == StRun) && (idx_q == IdxW'(C - 1));

  // One CHUNK-bit add per cycle; res_full is the partial sum with this cycle's slice merged in.
  always_comb begin
    chunk_res = {1'b0, a_q[idx_q * CHUNK +: CHUNK]}
              + {1'b0, b_q[idx_q * CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    res_full  = part_q;
    res_full[idx_q * CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          idx_d   = '0;
          a_d     = bus.num1;
          // Subtraction is A + ~B + 1.
          b_d     = bus.sub ? ~bus.num2 : bus.num2;
          carry_d = bus.sub | bus.cin;
        end
      end
      StRun: begin
        part_d  = res_full;
        carry_d = chunk_res[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (last) begin
          state_d = StIdle;
          idx_d   = '0;
          sum_d   = res_full;
          cout_d  = chunk_res[CHUNK];
          zero_d  = (res_full == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

`ifdef ADDER_SIGNED_FLAGS_EN
  logic neg_q, neg_d;
  logic ovf_q, ovf_d;

  // b_q already holds the effective (inverted for sub) operand.
  always_comb begin
    neg_d = neg_q;
    ovf_d = ovf_q;
    if (last) begin
      neg_d = res_full[N-1];
      ovf_d = (a_q[N-1] == b_q[N-1]) & (res_full[N-1] != a_q[N-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.neg = neg_q;
  assign bus.ovf = ovf_q;
`else
  assign bus.neg = 1'b0;
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy = (state_q == StRun);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.zero = zero_q;

endmodule

// File: doc/chunked_add_sub.md
# chunked_add_sub

- Multi-cycle, parametrised adder/subtractor.
- Processes the operands `CHUNK` bits per clock, LSB chunk first.
- Returns a registered `N`-bit result with carry, zero, negative and overflow flags, plus a start/busy/done handshake.
- Replaces the single-cycle combinational adder in datapaths where `N` is too wide to close timing in one cycle. Sits between the operand registers and the result/flag register file.

## Interface
- `N`, 8: operand/result width. Must be a multiple of `CHUNK`.
- `CHUNK`, 4: bits processed per cycle. `C = N/CHUNK` chunk cycles per operation.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request. Accepted only on an edge where `busy`=0.
- `num1` input N: operand A, sampled on the accepting edge.
- `num2` input N: operand B, sampled on the accepting edge.
- `cin` input 1: carry-in for add. Ignored when `sub`=1.
- `sub` input 1: 0 = A+B+cin; 1 = A−B (A + ~B + 1).
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse when results update.
- `sum` output N: result register.
- `cout` output 1: carry out of bit N−1. For sub, 1 = no borrow.
- `zero` output 1: `sum` == 0.
- `neg` output 1: `sum[N-1]`.
- `ovf` output 1: signed overflow.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, with chunk counter `idx` running 0..C−1.
- IDLE→RUN on an edge with `start`=1. That edge latches:
  - A = `num1`;
  - B = `num2`, or ~`num2` if `sub`=1;
  - carry = `cin`, or 1 if `sub`=1;
  - `idx`=0.
- Each RUN edge:
  - adds A[idx·CHUNK +: CHUNK] + B[same slice] + carry;
  - writes that slice of an internal partial-sum register;
  - updates the carry;
  - increments `idx`.
- On the RUN edge with `idx`=C−1:
  - loads `sum`, `cout`, `zero`, `neg`, `ovf` from the completed result;
  - sets `done`=1;
  - returns to IDLE.
- `ovf` = (A[N−1] == B[N−1]) & (result[N−1] != A[N−1]), using the effective (possibly inverted) B.
- Output registers hold their value from one `done` until the next `done`. They do not change during RUN.
- `start` while `busy`=1 is ignored. No queuing, no error flag.
- `start` in the `done` cycle is accepted, because `busy` is already 0.
- Operand inputs may change freely after the accepting edge.
- `rst_n`=0 at any time, including mid-RUN:
  - all outputs and internal state go to 0 immediately;
  - state goes to IDLE;
  - the partial operation is discarded and no `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, `zero`=0, `neg`=0, `ovf`=0.
- `zero` resets to 0 even though `sum`=0. It is a flag of the last completed result only.
- Accepting edge k:
  - `busy`=1 from after edge k through after edge k+C−1;
  - after edge k+C: `busy`=0, `done`=1 and results valid;
  - after edge k+C+1: `done`=0.
- Latency: C+1 edges from the accepting edge to `done` visible. Back-to-back throughput is one result per C+1 cycles.
- Per-cycle combinational path is one CHUNK-bit add plus carry.

## Configuration
- `ADDER_SIGNED_FLAGS_EN` defined: `neg` and `ovf` are computed and registered as described.
- Undefined:
  - `neg` and `ovf` are constant 0;
  - their registers and overflow logic are removed;
  - `sum`, `cout`, `zero` and timing are unchanged.

## Test plan
All scenarios use N=8, CHUNK=4, C=2.
- Add: `num1`=8'h3C, `num2`=8'h0F, `cin`=0, `sub`=0 → `done` 3 edges after accept (accept edge + 2); `sum`=8'h4B, `cout`=0, `zero`=0, `neg`=0, `ovf`=0.
- Wrap: 8'hFF + 8'h01, `cin`=0 → `sum`=8'h00, `cout`=1, `zero`=1, `neg`=0, `ovf`=0.
- Signed:
  - 8'h7F + 8'h01 → `sum`=8'h80, `neg`=1, `ovf`=1, `cout`=0.
  - `sub`=1, 8'h50 − 8'h60 → `sum`=8'hF0, `cout`=0, `neg`=1, `ovf`=0.
- Handshake:
  - `start` held high for 6 cycles with changing operands → exactly one `done` per C+1 cycles;
  - each result matches the operands sampled at its accepting edge;
  - `sum` is stable during `busy`.
- Reset mid-RUN: pull `rst_n` low after the first chunk edge → all outputs 0 immediately, no `done`. After release, 8'h01 + 8'h01 → 8'h02.
- Macro undefined: 8'h7F + 8'h01 → `sum`=8'h80, `neg`=0, `ovf`=0.
